// File: rtl/instr_encode_loader.sv
// Packs RV32I instruction fields into 32-bit words and writes them in order into an instruction-memory port.
// Latency 1 cycle from accept to imem_we; in_ready is low outside a load session and once DEPTH words are written.
module instr_encode_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        accept;
    logic        last_word;
    logic [31:0] enc_word;
    logic        enc_bad;

    logic signed [31:0] imm_s;
    logic               imm12_ok;
    logic               imm13_ok;
    logic               imm21_ok;
    logic               imm_u_ok;

    // start wins over a field set presented in the same cycle
    assign accept    = in_valid & (state_q == S_LOAD) & ~start;
    assign last_word = (word_count == LAST_IDX);

    assign imm_s    = imm;
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign imm13_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign imm21_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
    assign imm_u_ok = (imm[11:0] == 12'd0);

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_bad  = !imm12_ok;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_bad  = !imm12_ok;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_bad  = !imm13_ok;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                enc_bad  = !imm_u_ok;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_bad  = !imm21_ok;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        full     = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                in_ready = 1'b1;
                if (accept && last_word) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: full = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= enc_bad ? NOP : enc_word;
                word_count <= word_count + ONE;
                if (enc_bad) begin
                    err <= 1'b1;
                    // only the first bad set of a session is recorded
                    if (!err) begin
                        err_addr <= word_count[ADDR_W-1:0];
                    end
                end
            end
            if (start) begin
                word_count <= '0;
                err        <= 1'b0;
                err_addr   <= '0;
            end
        end
    end

endmodule
